// File: rtl/game_pkg.sv
// Shared definitions for the combat/HP logic: bullet color codes, scan FSM states and HP width.
package game_pkg;

  localparam int HP_W = 8;

  localparam logic [2:0] COLOR_DAMAGE      = 3'd0;
  localparam logic [2:0] COLOR_HEAL        = 3'd1;
  localparam logic [2:0] COLOR_MOVE_DAMAGE = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    APPLY
  } scan_state_e;

endpackage

// File: rtl/hp_scan_controller_hit_accumulator.sv
// Walks the bullet slots one per step and collects saturating damage plus a once-per-frame heal flag.
module hit_accumulator
  import game_pkg::*;
#(
  parameter int NUM_SLOTS    = 8,
  parameter int ATTACK_POWER = 10,
  parameter int SLOT_W       = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  input  logic              slot_collide,
  input  logic              slot_render,
  input  logic [2:0]        slot_color,
  input  logic              player_move,
  output logic [SLOT_W-1:0] slot_idx,
  output logic [HP_W-1:0]   acc_dmg,
  output logic              heal_flag,
  output logic              last_slot
);

  localparam logic [HP_W-1:0] ATK = HP_W'(ATTACK_POWER);

  logic          hit;
  logic          dmg_hit;
  logic [HP_W:0] dmg_sum;

  assign hit       = slot_collide && slot_render;
  assign dmg_hit   = hit && ((slot_color == COLOR_DAMAGE) ||
                             ((slot_color == COLOR_MOVE_DAMAGE) && player_move));
  assign dmg_sum   = {1'b0, acc_dmg} + {1'b0, ATK};
  assign last_slot = (slot_idx == SLOT_W'(NUM_SLOTS - 1));

  // Damage saturates at the 8-bit ceiling instead of wrapping back to a small value.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      slot_idx  <= '0;
      acc_dmg   <= '0;
      heal_flag <= 1'b0;
    end else if (step) begin
      slot_idx <= slot_idx + 1'b1;
      if (dmg_hit) begin
        acc_dmg <= dmg_sum[HP_W] ? {HP_W{1'b1}} : dmg_sum[HP_W-1:0];
      end
      if (hit && (slot_color == COLOR_HEAL)) begin
        heal_flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hp_scan_controller.sv
// Per-frame HP sequencer: scans bullet slots, then applies net damage/heal with invulnerability and game-over.
module hp_scan_controller
  import game_pkg::*;
#(
  parameter int NUM_SLOTS     = 8,
  parameter int ATTACK_POWER  = 10,
  parameter int HEAL_AMOUNT   = 5,
  parameter int MAX_HP        = 100,
  parameter int INVULN_FRAMES = 30,
  parameter int SLOT_W        = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic              new_round,
  output logic [SLOT_W-1:0] slot_idx,
  input  logic              slot_collide,
  input  logic              slot_render,
  input  logic [2:0]        slot_color,
  input  logic              player_move,
  output logic [HP_W-1:0]   hp,
  output logic              invuln,
  output logic              game_over,
  output logic              busy,
  output logic              scan_done,
  output logic              overrun
);

  localparam int INV_W = $clog2(INVULN_FRAMES + 1);

  scan_state_e       state_q, state_d;
  logic              acc_clear, acc_step, last_slot, heal_flag;
  logic [HP_W-1:0]   acc_dmg, eff_dmg, hp_after_dmg, hp_next;
  logic [HP_W:0]     heal_sum;
  logic [INV_W-1:0]  invuln_cnt;

  hit_accumulator #(
    .NUM_SLOTS    (NUM_SLOTS),
    .ATTACK_POWER (ATTACK_POWER),
    .SLOT_W       (SLOT_W)
  ) u_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (acc_clear),
    .step         (acc_step),
    .slot_collide (slot_collide),
    .slot_render  (slot_render),
    .slot_color   (slot_color),
    .player_move  (player_move),
    .slot_idx     (slot_idx),
    .acc_dmg      (acc_dmg),
    .heal_flag    (heal_flag),
    .last_slot    (last_slot)
  );

  assign busy   = (state_q != IDLE);
  assign invuln = (invuln_cnt != '0);

  always_comb begin
    state_d   = state_q;
    acc_clear = 1'b0;
    acc_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick && !game_over) begin
          state_d   = SCAN;
          acc_clear = 1'b1;
        end
      end
      SCAN: begin
        acc_step = 1'b1;
        if (last_slot) state_d = APPLY;
      end
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (new_round) begin
      state_d   = IDLE;
      acc_clear = 1'b1;
      acc_step  = 1'b0;
    end
  end

  // Damage is applied before heal, so a lethal frame stays lethal.
  always_comb begin
    eff_dmg      = invuln ? '0 : acc_dmg;
    hp_after_dmg = (eff_dmg >= hp) ? '0 : hp - eff_dmg;
    heal_sum     = {1'b0, hp_after_dmg} + (HP_W+1)'(HEAL_AMOUNT);
    hp_next      = hp_after_dmg;
    if (heal_flag && (hp_after_dmg != '0)) begin
      hp_next = (heal_sum > (HP_W+1)'(MAX_HP)) ? HP_W'(MAX_HP) : heal_sum[HP_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hp         <= HP_W'(MAX_HP);
      invuln_cnt <= '0;
      game_over  <= 1'b0;
      scan_done  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scan_done <= (state_q == APPLY) && !new_round;
      if (new_round) begin
        hp         <= HP_W'(MAX_HP);
        invuln_cnt <= '0;
        game_over  <= 1'b0;
        overrun    <= 1'b0;
      end else begin
        if (frame_tick && busy) overrun <= 1'b1;
        // A fresh hit reloads the window even if a frame_tick lands in the same cycle.
        if ((state_q == APPLY) && (eff_dmg != '0)) begin
          invuln_cnt <= INV_W'(INVULN_FRAMES);
        end else if (frame_tick && invuln) begin
          invuln_cnt <= invuln_cnt - 1'b1;
        end
        if (state_q == APPLY) begin
          hp <= hp_next;
          if (hp_next == '0) game_over <= 1'b1;
        end
      end
    end
  end

endmodule
